// File: rtl/tcp_tx_ctrl_arbiter.sv
// Shares one TX packet generator between several TCP socket state managers:
// one registered pending slot per socket, round-robin grant, single outstanding request.
package tcp_pkg;
  typedef enum logic [2:0] {
    TX_CTRL_NOP         = 3'd0,
    TX_CTRL_SEND_SYN    = 3'd1,
    TX_CTRL_SEND_SYNACK = 3'd2,
    TX_CTRL_SEND_ACK    = 3'd3,
    TX_CTRL_SEND_FIN    = 3'd4,
    TX_CTRL_SEND_FINACK = 3'd5,
    TX_CTRL_SEND_RST    = 3'd6
  } tx_ctrl_t;
endpackage

module tcp_tx_ctrl_arbiter
  import tcp_pkg::*;
#(
  parameter int unsigned NUM_SOCKETS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned SOCK_W         = $clog2(NUM_SOCKETS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_SOCKETS-1:0] i_enable,
  input  tx_ctrl_t               i_tx_ctrl [NUM_SOCKETS],
  input  logic [NUM_SOCKETS-1:0] i_tx_ctrl_valid,
  output logic [NUM_SOCKETS-1:0] o_tx_ctrl_ack,
  output logic                   o_pkt_req_valid,
  output tx_ctrl_t               o_pkt_req_ctrl,
  output logic [SOCK_W-1:0]      o_pkt_req_sock,
  input  logic                   i_pkt_req_ready,
  input  logic                   i_pkt_done,
  output logic [NUM_SOCKETS-1:0] o_drop,
  output logic                   o_timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SOCK_W-1:0]      r_rr_ptr;
  logic [SOCK_W-1:0]      r_sock;
  tx_ctrl_t               r_ctrl;
  logic [CNT_W-1:0]       r_tmo_cnt;
  logic                   r_timeout;
  logic [NUM_SOCKETS-1:0] r_pending;
  tx_ctrl_t               r_slot_ctrl [NUM_SOCKETS];
  logic [NUM_SOCKETS-1:0] r_drop;

  logic [NUM_SOCKETS-1:0] w_ack;
  logic [NUM_SOCKETS-1:0] w_req;
  logic                   w_grant_found;
  logic [SOCK_W-1:0]      w_grant_sock;
  logic                   w_sock_en;
  logic                   w_handshake;
  logic                   w_expire;

  // Only the registered pending bit gates acceptance; a slot freed this cycle stays busy.
  assign w_ack = i_rst_n ? (i_tx_ctrl_valid & i_enable & ~r_pending) : '0;
  assign w_req = r_pending & i_enable;

  always_comb begin
    int unsigned w_idx;
    logic [SOCK_W-1:0] w_pos;
    w_grant_found = 1'b0;
    w_grant_sock  = '0;
    w_idx         = 0;
    w_pos         = '0;
    for (int unsigned k = 0; k < NUM_SOCKETS; k++) begin
      w_idx = 32'(r_rr_ptr) + k;
      if (w_idx >= NUM_SOCKETS) begin
        w_idx = w_idx - NUM_SOCKETS;
      end
      w_pos = SOCK_W'(w_idx);
      if (!w_grant_found && w_req[w_pos]) begin
        w_grant_found = 1'b1;
        w_grant_sock  = w_pos;
      end
    end
  end

  assign w_sock_en   = i_enable[r_sock];
  assign w_handshake = (r_state == S_ISSUE) && w_sock_en && i_pkt_req_ready;
  assign w_expire    = (r_state == S_WAIT_DONE) && !i_pkt_done &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_found) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (!w_sock_en)           w_state_nxt = S_IDLE;
        else if (i_pkt_req_ready) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_pkt_done || w_expire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_sock    <= '0;
      r_ctrl    <= TX_CTRL_NOP;
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_expire;
      if (r_state == S_IDLE && w_grant_found) begin
        r_sock <= w_grant_sock;
        r_ctrl <= r_slot_ctrl[w_grant_sock];
      end
      // Counter holds cycles elapsed since handoff, so expiry lands TIMEOUT_CYCLES after it.
      if (w_handshake) begin
        r_rr_ptr  <= (r_sock == SOCK_W'(NUM_SOCKETS - 1)) ? '0 : r_sock + 1'b1;
        r_tmo_cnt <= CNT_W'(1);
      end else if (r_state == S_WAIT_DONE) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_drop    <= '0;
      for (int unsigned i = 0; i < NUM_SOCKETS; i++) begin
        r_slot_ctrl[i] <= TX_CTRL_NOP;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SOCKETS; i++) begin
        if (!i_enable[i]) begin
          r_pending[i] <= 1'b0;
          r_drop[i]    <= 1'b0;
        end else begin
          if (w_ack[i] && i_tx_ctrl[i] != TX_CTRL_NOP) begin
            r_pending[i]   <= 1'b1;
            r_slot_ctrl[i] <= i_tx_ctrl[i];
          end else if (w_handshake && r_sock == SOCK_W'(i)) begin
            r_pending[i] <= 1'b0;
          end
          if (i_tx_ctrl_valid[i] && r_pending[i]) begin
            r_drop[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign o_tx_ctrl_ack   = w_ack;
  assign o_pkt_req_valid = (r_state == S_ISSUE) && w_sock_en;
  assign o_pkt_req_ctrl  = r_ctrl;
  assign o_pkt_req_sock  = r_sock;
  assign o_drop          = r_drop;
  assign o_timeout       = r_timeout;

endmodule

// File: tb/tb_tcp_tx_ctrl_arbiter.sv
// Scenario bench for tcp_tx_ctrl_arbiter: expected grants queued at request time,
// popped and compared when the generator request appears.
module tb_tcp_tx_ctrl_arbiter;
  import tcp_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   en, vld, ack, drop;
  tx_ctrl_t       ctrl [N];
  logic           req_valid, ready, done, tmo;
  tx_ctrl_t       req_ctrl;
  logic [1:0]     req_sock;

  typedef struct packed {
    logic [1:0] sock;
    tx_ctrl_t   ctrl;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tcp_tx_ctrl_arbiter #(.NUM_SOCKETS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (en),
    .i_tx_ctrl       (ctrl),
    .i_tx_ctrl_valid (vld),
    .o_tx_ctrl_ack   (ack),
    .o_pkt_req_valid (req_valid),
    .o_pkt_req_ctrl  (req_ctrl),
    .o_pkt_req_sock  (req_sock),
    .i_pkt_req_ready (ready),
    .i_pkt_done      (done),
    .o_drop          (drop),
    .o_timeout       (tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = req_valid;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      ok = req_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '1; vld = '1; ready = 1'b0; done = 1'b0;
    for (int i = 0; i < N; i++) ctrl[i] = TX_CTRL_SEND_SYN;
    tick(); tick();
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", req_valid); end
    n_tests++; if (req_sock !== 2'd0) begin n_fail++; $display("FAIL reset_sock: got %0d want 0", req_sock); end
    n_tests++; if (req_ctrl !== TX_CTRL_NOP) begin n_fail++; $display("FAIL reset_ctrl: got %0d want 0", req_ctrl); end
    n_tests++; if (drop !== 4'b0000) begin n_fail++; $display("FAIL reset_drop: got %b want 0000", drop); end
    n_tests++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    vld = '0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_syn();
    exp_t e;
    bit   seen;
    ready = 1'b1;
    ctrl[1] = TX_CTRL_SEND_SYN; vld[1] = 1'b1; #1;
    n_tests++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL syn_ack: got %b want 0010", ack); end
    q.push_back('{sock: 2'd1, ctrl: TX_CTRL_SEND_SYN});
    tick(); vld = '0;
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL syn_early: got valid %b at t+1 want 0", req_valid); end
    tick();
    n_tests++;
    if (req_valid !== 1'b1 || q.size() == 0) begin
      n_fail++; $display("FAIL syn_t2: got valid %b at t+2 want 1", req_valid);
    end else begin
      e = q.pop_front();
      if ({req_sock, req_ctrl} !== e) begin
        n_fail++; $display("FAIL syn_grant: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", req_sock, req_ctrl, e.sock, e.ctrl);
      end
    end
    tick();
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL syn_wait: got valid %b in WAIT_DONE want 0", req_valid); end
    done = 1'b1; tick(); done = 1'b0;
    ctrl[1] = TX_CTRL_NOP; vld[1] = 1'b1; #1;
    n_tests++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL nop_ack: got %b want 0010", ack); end
    tick(); vld = '0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen |= req_valid;
      tick();
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL nop_discard: got request %b want none", seen); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   ok;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    ready = 1'b1;
    ctrl[0] = TX_CTRL_SEND_SYN; ctrl[2] = TX_CTRL_SEND_SYNACK; ctrl[3] = TX_CTRL_SEND_RST;
    vld = 4'b1101; #1;
    n_tests++; if (ack !== 4'b1101) begin n_fail++; $display("FAIL rr_ack: got %b want 1101", ack); end
    q.push_back('{sock: 2'd0, ctrl: TX_CTRL_SEND_SYN});
    q.push_back('{sock: 2'd2, ctrl: TX_CTRL_SEND_SYNACK});
    q.push_back('{sock: 2'd3, ctrl: TX_CTRL_SEND_RST});
    tick(); vld = '0;
    for (int g = 0; g < 5; g++) begin
      wait_req(ok);
      n_tests++;
      if (!ok || q.size() == 0) begin
        n_fail++; $display("FAIL rr_grant%0d: got no request (queued %0d) want one", g, q.size());
      end else begin
        e = q.pop_front();
        if ({req_sock, req_ctrl} !== e) begin
          n_fail++; $display("FAIL rr_grant%0d: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", g, req_sock, req_ctrl, e.sock, e.ctrl);
        end
      end
      tick();
      if (g == 1) begin
        ctrl[0] = TX_CTRL_SEND_ACK; ctrl[1] = TX_CTRL_SEND_FIN; vld = 4'b0011; #1;
        n_tests++; if (ack !== 4'b0011) begin n_fail++; $display("FAIL rr_reack: got %b want 0011", ack); end
        q.push_back('{sock: 2'd0, ctrl: TX_CTRL_SEND_ACK});
        q.push_back('{sock: 2'd1, ctrl: TX_CTRL_SEND_FIN});
      end
      tick(); vld = '0;
      tick(); done = 1'b1;
      tick(); done = 1'b0;
    end
  endtask

  task automatic test_drop();
    exp_t e;
    bit   ok;
    ready = 1'b0;
    ctrl[2] = TX_CTRL_SEND_SYN; vld[2] = 1'b1; #1;
    n_tests++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL drop_first_ack: got %b want 0100", ack); end
    q.push_back('{sock: 2'd2, ctrl: TX_CTRL_SEND_SYN});
    tick(); vld = '0;
    wait_req(ok);
    n_tests++;
    if (!ok || q.size() == 0) begin
      n_fail++; $display("FAIL drop_grant: got no request want one");
    end else begin
      e = q.pop_front();
      if ({req_sock, req_ctrl} !== e) begin
        n_fail++; $display("FAIL drop_grant: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", req_sock, req_ctrl, e.sock, e.ctrl);
      end
    end
    ctrl[2] = TX_CTRL_SEND_ACK; vld[2] = 1'b1; #1;
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL drop_ack: got %b want 0000", ack); end
    tick(); vld = '0;
    n_tests++; if (drop !== 4'b0100) begin n_fail++; $display("FAIL drop_set: got %b want 0100", drop); end
    tick();
    n_tests++; if (drop !== 4'b0100) begin n_fail++; $display("FAIL drop_sticky: got %b want 0100", drop); end
    en[2] = 1'b0; tick(); en[2] = 1'b1; #1;
    n_tests++; if (drop !== 4'b0000) begin n_fail++; $display("FAIL drop_clear: got %b want 0000", drop); end
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL drop_abort: got valid %b want 0", req_valid); end
    ctrl[2] = TX_CTRL_NOP; vld[2] = 1'b1; #1;
    n_tests++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL drop_pend_clear: got ack %b want 0100", ack); end
    tick(); vld = '0;
  endtask

  task automatic test_stall_abort();
    exp_t e;
    exp_t held;
    bit   ok;
    ready = 1'b0;
    held = '{sock: 2'd3, ctrl: TX_CTRL_SEND_SYNACK};
    ctrl[3] = TX_CTRL_SEND_SYNACK; vld[3] = 1'b1; #1;
    n_tests++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL stall_ack: got %b want 1000", ack); end
    q.push_back(held);
    tick(); vld = '0;
    wait_req(ok);
    n_tests++;
    if (!ok || q.size() == 0) begin
      n_fail++; $display("FAIL stall_grant: got no request want one");
    end else begin
      e = q.pop_front();
      if ({req_sock, req_ctrl} !== e) begin
        n_fail++; $display("FAIL stall_grant: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", req_sock, req_ctrl, e.sock, e.ctrl);
      end
    end
    ctrl[0] = TX_CTRL_SEND_FIN; ctrl[2] = TX_CTRL_SEND_RST; vld = 4'b0101; #1;
    n_tests++; if (ack !== 4'b0101) begin n_fail++; $display("FAIL stall_side_ack: got %b want 0101", ack); end
    tick(); vld = '0;
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if ({req_valid, req_sock, req_ctrl} !== {1'b1, held}) begin
        n_fail++; $display("FAIL stall_hold%0d: got valid=%b sock=%0d ctrl=%0d want 1/3/%0d", c, req_valid, req_sock, req_ctrl, held.ctrl);
      end
      tick();
    end
    en[3] = 1'b0; tick(); en[3] = 1'b1; #1;
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_abort: got valid %b want 0", req_valid); end
    q.push_back('{sock: 2'd2, ctrl: TX_CTRL_SEND_RST});
    q.push_back('{sock: 2'd0, ctrl: TX_CTRL_SEND_FIN});
    ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      wait_req(ok);
      n_tests++;
      if (!ok || q.size() == 0) begin
        n_fail++; $display("FAIL stall_rr%0d: got no request want one", g);
      end else begin
        e = q.pop_front();
        if ({req_sock, req_ctrl} !== e) begin
          n_fail++; $display("FAIL stall_rr%0d: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", g, req_sock, req_ctrl, e.sock, e.ctrl);
        end
      end
      tick(); done = 1'b1; tick(); done = 1'b0;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   ok;
    ready = 1'b1;
    ctrl[1] = TX_CTRL_SEND_SYN; ctrl[3] = TX_CTRL_SEND_FIN; vld = 4'b1010; #1;
    n_tests++; if (ack !== 4'b1010) begin n_fail++; $display("FAIL tmo_ack: got %b want 1010", ack); end
    q.push_back('{sock: 2'd1, ctrl: TX_CTRL_SEND_SYN});
    q.push_back('{sock: 2'd3, ctrl: TX_CTRL_SEND_FIN});
    tick(); vld = '0;
    wait_req(ok);
    n_tests++;
    if (!ok || q.size() == 0) begin
      n_fail++; $display("FAIL tmo_grant: got no request want one");
    end else begin
      e = q.pop_front();
      if ({req_sock, req_ctrl} !== e) begin
        n_fail++; $display("FAIL tmo_grant: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", req_sock, req_ctrl, e.sock, e.ctrl);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tests++;
      if (tmo !== (k == TMO)) begin n_fail++; $display("FAIL tmo_pulse%0d: got %b want %b", k, tmo, (k == TMO)); end
      n_tests++;
      if (req_valid !== (k == TMO + 1)) begin n_fail++; $display("FAIL tmo_valid%0d: got %b want %b", k, req_valid, (k == TMO + 1)); end
      if (k == TMO + 1 && req_valid === 1'b1 && q.size() != 0) begin
        e = q.pop_front();
        n_tests++;
        if ({req_sock, req_ctrl} !== e) begin
          n_fail++; $display("FAIL tmo_next: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", req_sock, req_ctrl, e.sock, e.ctrl);
        end
      end
    end
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    bit   ok;
    ready = 1'b1;
    ctrl[0] = TX_CTRL_SEND_ACK; vld = 4'b0001;
    q.push_back('{sock: 2'd0, ctrl: TX_CTRL_SEND_ACK});
    tick(); vld = '0;
    wait_req(ok);
    n_tests++;
    if (!ok || q.size() == 0) begin
      n_fail++; $display("FAIL rstmid_grant: got no request want one");
    end else begin
      e = q.pop_front();
      if ({req_sock, req_ctrl} !== e) begin
        n_fail++; $display("FAIL rstmid_grant: got sock=%0d ctrl=%0d want sock=%0d ctrl=%0d", req_sock, req_ctrl, e.sock, e.ctrl);
      end
    end
    tick();
    for (int i = 0; i < N; i++) ctrl[i] = TX_CTRL_SEND_SYN;
    vld = '1; #1;
    n_tests++; if (ack !== 4'b1111) begin n_fail++; $display("FAIL rstmid_fill: got ack %b want 1111", ack); end
    tick();
    rst_n = 1'b0; #1;
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack_low: got %b want 0000", ack); end
    tick();
    n_tests++;
    if ({req_valid, req_sock, req_ctrl, drop, tmo, ack} !== {1'b0, 2'd0, TX_CTRL_NOP, 4'b0000, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL rstmid_outputs: got valid=%b sock=%0d ctrl=%0d drop=%b tmo=%b ack=%b want all 0",
                         req_valid, req_sock, req_ctrl, drop, tmo, ack);
    end
    vld = '0; rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen |= req_valid;
      if (c == 1) done = 1'b1;
      else done = 1'b0;
    end
    done = 1'b0;
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_abandon: got request %b want none", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_syn();
    test_round_robin();
    test_drop();
    test_stall_abort();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
